// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard hazard unit: decode stalls, E-stage bubbles, MDU interlock
// and a multi-cycle exception flush window for the five-stage pipeline.
module hazard_scoreboard #(
    parameter int unsigned NREG       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned CW         = 3,
    parameter int unsigned FLUSH_HOLD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_early,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_wd,
    input  logic [CW-1:0] id_lat,
    input  logic          id_mdu_start,
    input  logic          id_mdu_read,
    input  logic          mdu_done,
    input  logic          except_flush,
    output logic          stallF,
    output logic          stallD,
    output logic          flushF,
    output logic          flushD,
    output logic          flushE,
    output logic          flushM,
    output logic          flushW,
    output logic          mdu_busy
);

    localparam int unsigned HW = (FLUSH_HOLD > 2) ? $clog2(FLUSH_HOLD) : 1;

    typedef enum logic {RUN, HOLD} flushState_t;

    flushState_t   stateQ, stateD;
    logic [HW-1:0] holdQ, holdD;
    logic [CW-1:0] cntQ [NREG];
    logic [CW-1:0] cntD [NREG];
    logic          mduBusyQ, mduBusyD;
    logic          flushAll;
    logic          opHazard;
    logic          mduHazard;
    logic          issue;
    logic [CW-1:0] thr;

    // Flush window FSM: the cycle of except_flush counts as the first flushed cycle
    always_comb begin
        flushAll = 1'b0;
        stateD   = stateQ;
        holdD    = holdQ;
        case (stateQ)
            RUN: begin
                if (except_flush) begin
                    flushAll = 1'b1;
                    if (FLUSH_HOLD > 1) begin
                        stateD = HOLD;
                        holdD  = HW'(FLUSH_HOLD - 1);
                    end
                end
            end
            HOLD: begin
                flushAll = 1'b1;
                if (except_flush) begin
                    holdD = HW'(FLUSH_HOLD - 1);
                end else if (holdQ <= HW'(1)) begin
                    stateD = RUN;
                end else begin
                    holdD = holdQ - HW'(1);
                end
            end
            default: stateD = RUN;
        endcase
    end

    // Hazard detection, issue qualification and scoreboard next state
    always_comb begin
        thr      = id_early ? CW'(0) : CW'(1);
        opHazard = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (id_use_rs && id_rs == AW'(r) && cntQ[r] > thr) opHazard = 1'b1;
            if (id_use_rt && id_rt == AW'(r) && cntQ[r] > thr) opHazard = 1'b1;
        end
        mduHazard = (id_mdu_read | id_mdu_start) & mduBusyQ & ~mdu_done;

        stallD = id_valid & (opHazard | mduHazard) & ~flushAll;
        stallF = stallD;
        flushF = flushAll;
        flushD = flushAll;
        flushE = stallD | flushAll;
        flushM = flushAll;
        flushW = flushAll;
        issue  = id_valid & ~stallD & ~flushAll;

        // A new write overrides the register's own decrement in the same cycle
        cntD[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cntD[r] = cntQ[r];
            if (flushAll) begin
                cntD[r] = '0;
            end else if (issue && id_wr_en && id_wd == AW'(r)) begin
                cntD[r] = id_lat;
            end else if (cntQ[r] != '0) begin
                cntD[r] = cntQ[r] - CW'(1);
            end
        end

        mduBusyD = mduBusyQ;
        if (flushAll) begin
            mduBusyD = 1'b0;
        end else if (issue && id_mdu_start) begin
            mduBusyD = 1'b1;
        end else if (mdu_done) begin
            mduBusyD = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= RUN;
            holdQ    <= '0;
            mduBusyQ <= 1'b0;
            for (int unsigned r = 0; r < NREG; r++) cntQ[r] <= '0;
        end else begin
            stateQ   <= stateD;
            holdQ    <= holdD;
            mduBusyQ <= mduBusyD;
            for (int unsigned r = 0; r < NREG; r++) cntQ[r] <= cntD[r];
        end
    end

    assign mdu_busy = mduBusyQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a three-cycle flush window.
module tb_hazard_scoreboard;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs, id_use_rt, id_early, id_wr_en;
    logic [AW-1:0] id_rs, id_rt, id_wd;
    logic [CW-1:0] id_lat;
    logic          id_mdu_start, id_mdu_read, mdu_done, except_flush;
    logic          stallF, stallD, flushF, flushD, flushE, flushM, flushW, mdu_busy;

    int compared   = 0;
    int mismatched = 0;

    hazard_scoreboard #(.NREG(32), .AW(AW), .CW(CW), .FLUSH_HOLD(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
        .id_wr_en(id_wr_en), .id_wd(id_wd), .id_lat(id_lat),
        .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read), .mdu_done(mdu_done),
        .except_flush(except_flush), .stallF(stallF), .stallD(stallD),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .flushW(flushW), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_early = 0; id_wr_en = 0;
        id_rs = '0; id_rt = '0; id_wd = '0; id_lat = '0;
        id_mdu_start = 0; id_mdu_read = 0; mdu_done = 0; except_flush = 0;
    endtask

    task automatic producer(input logic [AW-1:0] wd, input logic [CW-1:0] lat);
        idle();
        id_valid = 1; id_wr_en = 1; id_wd = wd; id_lat = lat;
    endtask

    task automatic reader(input logic [AW-1:0] rs, input logic early);
        idle();
        id_valid = 1; id_use_rs = 1; id_rs = rs; id_early = early;
    endtask

    function automatic logic [7:0] flushVec();
        return {3'b000, flushF, flushD, flushE, flushM, flushW};
    endfunction

    initial begin
        idle();
        rst = 1;
        #2;
        chk("rst_stallD", 8'(stallD), 8'd0);
        chk("rst_busy", 8'(mdu_busy), 8'd0);
        chk("rst_flush_idle", flushVec(), 8'h00);
        except_flush = 1;
        #1;
        chk("rst_flush_follow", flushVec(), 8'h1f);
        except_flush = 0;
        tick();
        tick();
        rst = 0;

        // Load r5 then dependent add
        producer(5, 2);
        #1 chk("load_issue_stall", 8'(stallD), 8'd0);
        tick();
        producer(6, 1); id_use_rs = 1; id_rs = 5;
        #1 chk("load_use_stallD", 8'(stallD), 8'd1);
        chk("load_use_stallF", 8'(stallF), 8'd1);
        chk("load_use_flushE", 8'(flushE), 8'd1);
        tick();
        #1 chk("load_use_release", 8'(stallD), 8'd0);
        chk("load_use_no_bubble", 8'(flushE), 8'd0);
        tick();
        idle(); tick();

        // Load then branch: two stalls
        producer(5, 2); tick();
        reader(5, 1);
        #1 chk("load_br_c1", 8'(stallD), 8'd1);
        tick();
        #1 chk("load_br_c2", 8'(stallD), 8'd1);
        tick();
        #1 chk("load_br_c3", 8'(stallD), 8'd0);
        tick();

        // ALU then branch: one stall; ALU then normal: none
        producer(8, 1); tick();
        reader(8, 1);
        #1 chk("alu_br_c1", 8'(stallD), 8'd1);
        tick();
        #1 chk("alu_br_c2", 8'(stallD), 8'd0);
        tick();
        producer(8, 1); tick();
        reader(8, 0);
        #1 chk("alu_use_nostall", 8'(stallD), 8'd0);
        tick();

        // r0 is never tracked; untouched r9 does not stall
        producer(0, 7); tick();
        reader(0, 1); id_use_rt = 1; id_rt = 0;
        #1 chk("r0_nostall", 8'(stallD), 8'd0);
        reader(9, 1);
        #1 chk("r9_nostall", 8'(stallD), 8'd0);
        tick();

        // Divide then mfhi waiting on mdu_done
        idle(); id_valid = 1; id_mdu_start = 1;
        #1 chk("div_issue", 8'(stallD), 8'd0);
        tick();
        chk("div_busy", 8'(mdu_busy), 8'd1);
        idle(); id_valid = 1; id_mdu_read = 1;
        for (int i = 0; i < 10; i++) begin
            #1 chk($sformatf("mfhi_wait%0d", i), 8'(stallD), 8'd1);
            tick();
        end
        mdu_done = 1;
        #1 chk("mfhi_done_issue", 8'(stallD), 8'd0);
        tick();
        idle();
        #1 chk("mfhi_busy_clear", 8'(mdu_busy), 8'd0);

        // Start and done in the same cycle: start wins
        id_valid = 1; id_mdu_start = 1; tick();
        mdu_done = 1;
        #1 chk("start_done_nostall", 8'(stallD), 8'd0);
        tick();
        idle();
        #1 chk("start_wins", 8'(mdu_busy), 8'd1);
        mdu_done = 1; tick();
        idle();
        #1 chk("done_clears", 8'(mdu_busy), 8'd0);

        // Flush window clears scoreboard and MDU, overrides stall
        producer(3, 5); id_mdu_start = 1; tick();
        #1 chk("pre_flush_busy", 8'(mdu_busy), 8'd1);
        reader(3, 1); except_flush = 1;
        #1 chk("flush_c0_vec", flushVec(), 8'h1f);
        chk("flush_c0_nostall", 8'(stallD), 8'd0);
        tick();
        except_flush = 0;
        #1 chk("flush_c1_vec", flushVec(), 8'h1f);
        chk("flush_c1_nostall", 8'(stallD), 8'd0);
        tick();
        #1 chk("flush_c2_vec", flushVec(), 8'h1f);
        tick();
        #1 chk("flush_end_vec", flushVec(), 8'h00);
        chk("flush_r3_nostall", 8'(stallD), 8'd0);
        chk("flush_busy_clear", 8'(mdu_busy), 8'd0);
        tick();

        // Reload while holding stretches the window
        idle(); except_flush = 1; tick();
        #1 chk("reload_c1_vec", flushVec(), 8'h1f);
        tick();
        except_flush = 0;
        #1 chk("reload_c2_vec", flushVec(), 8'h1f);
        tick();
        #1 chk("reload_c3_vec", flushVec(), 8'h1f);
        tick();
        #1 chk("reload_end_vec", flushVec(), 8'h00);
        tick();

        // Reissue overrides decrement; async reset mid-countdown
        producer(7, 1); tick();
        producer(7, 4); id_mdu_start = 1; tick();
        reader(7, 1);
        #1 chk("reissue_c1", 8'(stallD), 8'd1);
        chk("reissue_busy", 8'(mdu_busy), 8'd1);
        tick();
        #1 chk("reissue_c2", 8'(stallD), 8'd1);
        rst = 1;
        #1 chk("async_rst_stall", 8'(stallD), 8'd0);
        chk("async_rst_bubble", 8'(flushE), 8'd0);
        chk("async_rst_busy", 8'(mdu_busy), 8'd0);
        tick();
        rst = 0;
        #1 chk("post_rst_stall", 8'(stallD), 8'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
